n64_snac_xfer: RTL and testbench
================================

Name: n64_snac_xfer

Overview:
- Transaction sequencer directly upstream of the N64 SNAC bit-level Joybus engine.
- Accepts a whole Joybus request from the PIF/controller logic: TX bytes written into a local buffer, plus TX and RX lengths.
- Feeds the engine one byte at a time, collects response bytes into an RX buffer, and reports one completion status per transaction.

Parameters:
- MAX_BYTES, 40: depth of each of the TX and RX buffers; lengths 1..MAX_BYTES are legal.
- WDOG_CYCLES, 20000: abort threshold in clk_1x cycles without progress; only used with the optional feature.

Ports:
- clk_1x  in  1  system clock (64 cycles = 1 us).
- reset  in  1  reset; synchronous, active-low.
- txwr_en  in  1  TX buffer write strobe.
- txwr_addr  in  6  TX buffer write index.
- txwr_data  in  8  TX buffer write byte.
- req_valid  in  1  start-transaction request.
- req_ready  out  1  high while IDLE.
- req_txlen  in  6  bytes to send; sampled when req_valid && req_ready.
- req_rxlen  in  6  bytes expected; sampled with req_txlen.
- rd_addr  in  6  RX buffer read index.
- rd_data  out  8  RX byte; registered, 1-cycle read latency.
- done  out  1  one-cycle completion pulse.
- status  out  2  result: 00 ok, 01 pad timeout, 10 bad length, 11 watchdog. Valid from done until the next accept.
- rx_count  out  6  RX bytes stored; valid with status.
- snac_start  out  1  start pulse to the engine.
- snac_cmdData  out  8  current TX byte to the engine.
- snac_sendCnt  out  6  equals the latched txlen.
- snac_receiveCnt  out  6  equals the latched rxlen.
- snac_toPad_ena  out  1  next-byte release pulse to the engine.
- snac_ready  in  1  engine ready.
- snac_byteRec  in  1  engine byte-received pulse.
- snac_dataOut  in  8  engine received byte.
- snac_timeout  in  1  engine timeout pulse.

Behaviour:
- Reset (reset==0 at a clk_1x edge):
  - State goes to IDLE.
  - Outputs: req_ready=1, done=0, status=00, rx_count=0, snac_start=0, snac_toPad_ena=0, snac_cmdData=0, snac_sendCnt=0, snac_receiveCnt=0, rd_data=0.
  - Buffer contents are not cleared.
  - Reset mid-transaction aborts with no done pulse.
- Buffers:
  - TX writes are accepted only in IDLE; writes in other states are dropped.
  - RX reads are allowed in any state.
  - Out-of-range addresses: writes are ignored, reads return 0.
- All outputs are registered.
- IDLE:
  - On req_valid, latch txlen/rxlen and clear rx_count.
  - If either length is 0 or exceeds MAX_BYTES: next cycle done=1, status=10, stay IDLE.
  - Otherwise: tx_idx=0, snac_cmdData=TX[0], go to ARM.
- ARM:
  - Wait for snac_ready==1.
  - Then pulse snac_start for exactly 1 cycle, go to SEND_WAITLO.
- SEND_WAITLO:
  - Wait until snac_ready==0. This blocks the engine's idle-ready from being mistaken for next-byte-ready.
  - Then go to SEND.
- SEND:
  - If tx_idx==txlen-1: go to RECV. The engine sends the stop bit itself; no further pulses are issued.
  - Else, on snac_ready==1, in the same cycle:
    - increment tx_idx;
    - drive snac_cmdData=TX[tx_idx+1];
    - pulse snac_toPad_ena for 1 cycle;
    - go to SEND_WAITLO.
  - snac_cmdData is held stable from that edge until the next pulse, because the engine samples it bit by bit.
- RECV:
  - Each snac_byteRec pulse: write snac_dataOut to RX[rx_count], then increment rx_count (saturating at MAX_BYTES).
  - When the increment makes rx_count==rxlen: next cycle done=1, status=00, go to IDLE.
  - snac_timeout in RECV: next cycle done=1, status=01, rx_count keeps the bytes already stored, go to IDLE.
  - If byteRec and timeout arrive in the same cycle: store the byte first, then report the result by rx_count (==rxlen gives 00, otherwise 01).
- Stray inputs: snac_byteRec or snac_timeout outside RECV is ignored.
- Latency: done asserts 1 cycle after the final byteRec or the timeout edge. req_ready returns high in the same cycle as done.
- Back-to-back requests: a new req_valid is accepted the cycle after done.

Optional Feature:
- SNAC_XFER_WDOG_EN defined:
  - A 15-bit counter clears on accept, on every snac_ready transition, and on every byteRec; it counts in all non-IDLE states.
  - Reaching WDOG_CYCLES gives: done=1, status=11, return to IDLE, snac_toPad_ena and snac_start forced 0.
  - The engine is expected to recover through its own timeout.
- SNAC_XFER_WDOG_EN undefined: no counter is built, status 11 never occurs, and a hung engine leaves the block in its current state until reset.

Test Plan:
- TX[0]=0x00, txlen=1, rxlen=3; engine model returns 05 00 02 -> one snac_start, zero toPad_ena pulses, done with status=00, rx_count=3, RX reads 05,00,02.
- TX=02 80 01, txlen=3, rxlen=33 -> snac_cmdData sequence 02,80,01, exactly 2 toPad_ena pulses each coincident with the cmdData change, 33 bytes stored, status=00.
- txlen=1, rxlen=3; model sends 1 byte then asserts snac_timeout -> status=01, rx_count=1, RX[0] correct.
- req_txlen=0 (and separately rxlen=41) -> done 1 cycle after accept, status=10, no snac_start.
- Drive reset low during SEND -> all outputs at reset values next cycle, no done; the following request completes normally.
- SNAC_XFER_WDOG_EN with the model holding snac_ready low forever after start -> done with status=11 after 20000 cycles.

Source files
------------

// File: rtl/n64_snac_xfer_if.sv
// rtl/n64_snac_xfer_if.sv - link between the transaction sequencer and the SNAC Joybus bit engine
interface n64_snac_xfer_if;
  logic       snac_start;
  logic [7:0] snac_cmdData;
  logic [5:0] snac_sendCnt;
  logic [5:0] snac_receiveCnt;
  logic       snac_toPad_ena;
  logic       snac_ready;
  logic       snac_byteRec;
  logic [7:0] snac_dataOut;
  logic       snac_timeout;

  modport master (
    output snac_start, snac_cmdData, snac_sendCnt, snac_receiveCnt, snac_toPad_ena,
    input  snac_ready, snac_byteRec, snac_dataOut, snac_timeout
  );

  modport slave (
    input  snac_start, snac_cmdData, snac_sendCnt, snac_receiveCnt, snac_toPad_ena,
    output snac_ready, snac_byteRec, snac_dataOut, snac_timeout
  );
endinterface

// File: rtl/n64_snac_xfer.sv
// rtl/n64_snac_xfer.sv - Joybus transaction sequencer: TX/RX buffers, byte pacing, completion status
// Optional stall watchdog enabled by defining SNAC_XFER_WDOG_EN.
module n64_snac_xfer #(
  parameter int MAX_BYTES = 40
`ifdef SNAC_XFER_WDOG_EN
  , parameter int WDOG_CYCLES = 20000
`endif
) (
  input  logic                  clk_1x,
  input  logic                  reset,
  input  logic                  txwr_en,
  input  logic [5:0]            txwr_addr,
  input  logic [7:0]            txwr_data,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [5:0]            req_txlen,
  input  logic [5:0]            req_rxlen,
  input  logic [5:0]            rd_addr,
  output logic [7:0]            rd_data,
  output logic                  done,
  output logic [1:0]            status,
  output logic [5:0]            rx_count,
  n64_snac_xfer_if.master       snac
);

  typedef enum logic [2:0] {IDLE, ARM, SEND_WAITLO, SEND, RECV} state_t;

  localparam logic [5:0] MAX_L = 6'(MAX_BYTES);

  state_t     state;
  logic [7:0] tx_mem [MAX_BYTES];
  logic [7:0] rx_mem [MAX_BYTES];
  logic [5:0] tx_idx;
  logic [5:0] rx_next;
  logic       rx_we;
  logic       len_bad;

`ifdef SNAC_XFER_WDOG_EN
  localparam logic [14:0] WDOG_LIM = 15'(WDOG_CYCLES);
  logic [14:0] wdog_cnt;
  logic        ready_q;
`endif

  always_comb begin
    rx_next = (rx_count == MAX_L) ? rx_count : rx_count + 6'd1;
    rx_we   = (state == RECV) && snac.snac_byteRec && (rx_count < MAX_L);
    len_bad = (req_txlen == 6'd0) || (req_txlen > MAX_L) ||
              (req_rxlen == 6'd0) || (req_rxlen > MAX_L);
  end

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk_1x) begin
    if (txwr_en && (state == IDLE) && (txwr_addr < MAX_L))
      tx_mem[txwr_addr] <= txwr_data;
    if (rx_we)
      rx_mem[rx_count] <= snac.snac_dataOut;
  end

  always_ff @(posedge clk_1x) begin
    if (!reset)
      rd_data <= 8'h00;
    else
      rd_data <= (rd_addr < MAX_L) ? rx_mem[rd_addr] : 8'h00;
  end

  always_ff @(posedge clk_1x) begin
    if (!reset) begin
      state                <= IDLE;
      req_ready            <= 1'b1;
      done                 <= 1'b0;
      status               <= 2'b00;
      rx_count             <= 6'd0;
      tx_idx               <= 6'd0;
      snac.snac_start      <= 1'b0;
      snac.snac_toPad_ena  <= 1'b0;
      snac.snac_cmdData    <= 8'h00;
      snac.snac_sendCnt    <= 6'd0;
      snac.snac_receiveCnt <= 6'd0;
`ifdef SNAC_XFER_WDOG_EN
      wdog_cnt             <= 15'd0;
      ready_q              <= 1'b0;
`endif
    end else begin
      done                <= 1'b0;
      snac.snac_start     <= 1'b0;
      snac.snac_toPad_ena <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            snac.snac_sendCnt    <= req_txlen;
            snac.snac_receiveCnt <= req_rxlen;
            rx_count             <= 6'd0;
            tx_idx               <= 6'd0;
            if (len_bad) begin
              done   <= 1'b1;
              status <= 2'b10;
            end else begin
              snac.snac_cmdData <= tx_mem[0];
              req_ready         <= 1'b0;
              state             <= ARM;
            end
          end
        end
        ARM: begin
          if (snac.snac_ready) begin
            snac.snac_start <= 1'b1;
            state           <= SEND_WAITLO;
          end
        end
        // The engine's idle-high ready must drop before it can mean "next byte".
        SEND_WAITLO: begin
          if (!snac.snac_ready)
            state <= SEND;
        end
        SEND: begin
          if (tx_idx == snac.snac_sendCnt - 6'd1) begin
            state <= RECV;
          end else if (snac.snac_ready) begin
            tx_idx              <= tx_idx + 6'd1;
            snac.snac_cmdData   <= tx_mem[tx_idx + 6'd1];
            snac.snac_toPad_ena <= 1'b1;
            state               <= SEND_WAITLO;
          end
        end
        RECV: begin
          if (snac.snac_byteRec) begin
            rx_count <= rx_next;
            if (rx_next == snac.snac_receiveCnt || snac.snac_timeout) begin
              done      <= 1'b1;
              status    <= (rx_next == snac.snac_receiveCnt) ? 2'b00 : 2'b01;
              req_ready <= 1'b1;
              state     <= IDLE;
            end
          end else if (snac.snac_timeout) begin
            done      <= 1'b1;
            status    <= 2'b01;
            req_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
`ifdef SNAC_XFER_WDOG_EN
      ready_q <= snac.snac_ready;
      if ((state == IDLE) || (snac.snac_ready != ready_q) || snac.snac_byteRec) begin
        wdog_cnt <= 15'd0;
      end else if (wdog_cnt == WDOG_LIM - 15'd1) begin
        wdog_cnt            <= 15'd0;
        done                <= 1'b1;
        status              <= 2'b11;
        req_ready           <= 1'b1;
        state               <= IDLE;
        snac.snac_start     <= 1'b0;
        snac.snac_toPad_ena <= 1'b0;
      end else begin
        wdog_cnt <= wdog_cnt + 15'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_n64_snac_xfer.sv
// tb/tb_n64_snac_xfer.sv - self-checking bench for n64_snac_xfer with a behavioural engine model
module tb_n64_snac_xfer;

  logic       clk_1x = 1'b0;
  logic       reset;
  logic       txwr_en;
  logic [5:0] txwr_addr;
  logic [7:0] txwr_data;
  logic       req_valid;
  logic       req_ready;
  logic [5:0] req_txlen;
  logic [5:0] req_rxlen;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       done;
  logic [1:0] status;
  logic [5:0] rx_count;

  n64_snac_xfer_if snac_if ();

  n64_snac_xfer dut (
    .clk_1x    (clk_1x),
    .reset     (reset),
    .txwr_en   (txwr_en),
    .txwr_addr (txwr_addr),
    .txwr_data (txwr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_txlen (req_txlen),
    .req_rxlen (req_rxlen),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .done      (done),
    .status    (status),
    .rx_count  (rx_count),
    .snac      (snac_if)
  );

  always #5 clk_1x = ~clk_1x;

  int checks = 0;
  int errors = 0;

  int n_start = 0;
  int n_topad = 0;
  int n_done  = 0;
  logic [7:0] cmd_log [$];
  logic [7:0] tx_model [40];
  logic [7:0] resp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk_1x) begin
    #1;
    if (snac_if.snac_start) begin
      n_start++;
      cmd_log.push_back(snac_if.snac_cmdData);
    end
    if (snac_if.snac_toPad_ena) begin
      n_topad++;
      cmd_log.push_back(snac_if.snac_cmdData);
    end
    if (done) n_done++;
  end

  task automatic load_tx(input int n);
    for (int i = 0; i < n; i++) begin
      txwr_en   = 1'b1;
      txwr_addr = 6'(i);
      txwr_data = tx_model[i];
      @(negedge clk_1x);
    end
    txwr_en = 1'b0;
  endtask

  task automatic wait_start(output logic got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_1x);
      got = snac_if.snac_start;
    end
  endtask

  // tmode: 0 = all bytes, 1 = timeout after nbytes, 2 = timeout with the last byte
  task automatic run_xact(input int txlen, input int rxlen, input int nbytes, input int tmode);
    int         s0, p0;
    logic       got;
    logic [7:0] d;
    logic [7:0] exp_rx [$];
    s0 = n_start;
    p0 = n_topad;
    cmd_log.delete();
    snac_if.snac_ready = 1'b1;
    req_txlen = 6'(txlen);
    req_rxlen = 6'(rxlen);
    req_valid = 1'b1;
    @(negedge clk_1x);
    req_valid = 1'b0;
    check("req_ready_busy", req_ready, 0);
    check("send_cnt", snac_if.snac_sendCnt, txlen);
    check("recv_cnt", snac_if.snac_receiveCnt, rxlen);
    wait_start(got);
    check("start_seen", got, 1);
    repeat ($urandom_range(0, 2)) @(negedge clk_1x);
    for (int b = 0; b < txlen; b++) begin
      snac_if.snac_ready = 1'b0;
      txwr_en   = 1'b1;
      txwr_addr = 6'($urandom_range(0, 39));
      txwr_data = 8'($urandom);
      @(negedge clk_1x);
      txwr_en = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk_1x);
      if (b < txlen - 1) begin
        snac_if.snac_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
          @(negedge clk_1x);
          got = snac_if.snac_toPad_ena;
        end
        check("topad_seen", got, 1);
        repeat ($urandom_range(0, 1)) @(negedge clk_1x);
      end
    end
    repeat ($urandom_range(2, 5)) @(negedge clk_1x);
    for (int k = 0; k < nbytes; k++) begin
      d = (resp_q.size() > 0) ? resp_q.pop_front() : 8'($urandom);
      exp_rx.push_back(d);
      snac_if.snac_byteRec = 1'b1;
      snac_if.snac_dataOut = d;
      if (tmode == 2 && k == nbytes - 1) snac_if.snac_timeout = 1'b1;
      @(negedge clk_1x);
      snac_if.snac_byteRec = 1'b0;
      snac_if.snac_timeout = 1'b0;
      snac_if.snac_dataOut = 8'($urandom);
      if (k < nbytes - 1) repeat ($urandom_range(0, 3)) @(negedge clk_1x);
    end
    if (tmode == 1) begin
      if (nbytes > 0) repeat ($urandom_range(0, 3)) @(negedge clk_1x);
      snac_if.snac_timeout = 1'b1;
      @(negedge clk_1x);
      snac_if.snac_timeout = 1'b0;
    end
    check("done_latency", done, 1);
    check("status", status, (nbytes == rxlen) ? 0 : 1);
    check("rx_count", rx_count, nbytes);
    check("req_ready_done", req_ready, 1);
    check("start_count", n_start - s0, 1);
    check("topad_count", n_topad - p0, txlen - 1);
    check("cmd_log_len", cmd_log.size(), txlen);
    for (int i = 0; i < txlen; i++) check("cmd_seq", cmd_log[i], tx_model[i]);
    snac_if.snac_ready = 1'b1;
    for (int k = 0; k < nbytes; k++) begin
      rd_addr = 6'(k);
      @(negedge clk_1x);
      check("rx_data", rd_data, exp_rx[k]);
    end
    rd_addr = 6'd45;
    @(negedge clk_1x);
    check("rd_out_of_range", rd_data, 0);
  endtask

  task automatic bad_len(input int txlen, input int rxlen);
    int s0;
    s0 = n_start;
    req_txlen = 6'(txlen);
    req_rxlen = 6'(rxlen);
    req_valid = 1'b1;
    @(negedge clk_1x);
    req_valid = 1'b0;
    check("bad_done", done, 1);
    check("bad_status", status, 2);
    check("bad_ready", req_ready, 1);
    check("bad_rx_count", rx_count, 0);
    @(negedge clk_1x);
    check("bad_done_pulse", done, 0);
    check("bad_no_start", n_start - s0, 0);
  endtask

  initial begin
    int   tl, rl, nb, tm, d0;
    logic got;
    reset = 1'b0;
    txwr_en = 1'b0; txwr_addr = 6'd0; txwr_data = 8'h00;
    req_valid = 1'b0; req_txlen = 6'd0; req_rxlen = 6'd0; rd_addr = 6'd63;
    snac_if.snac_ready = 1'b1; snac_if.snac_byteRec = 1'b0;
    snac_if.snac_dataOut = 8'h00; snac_if.snac_timeout = 1'b0;
    repeat (3) @(negedge clk_1x);
    check("rst_req_ready", req_ready, 1);
    check("rst_done", done, 0);
    check("rst_status", status, 0);
    check("rst_rx_count", rx_count, 0);
    check("rst_start", snac_if.snac_start, 0);
    check("rst_topad", snac_if.snac_toPad_ena, 0);
    check("rst_cmd", snac_if.snac_cmdData, 0);
    check("rst_sendcnt", snac_if.snac_sendCnt, 0);
    check("rst_recvcnt", snac_if.snac_receiveCnt, 0);
    check("rst_rd_data", rd_data, 0);
    reset = 1'b1;
    @(negedge clk_1x);

    tx_model[0] = 8'h00;
    load_tx(1);
    resp_q = '{8'h05, 8'h00, 8'h02};
    run_xact(1, 3, 3, 0);

    snac_if.snac_byteRec = 1'b1; snac_if.snac_timeout = 1'b1; snac_if.snac_dataOut = 8'hAA;
    @(negedge clk_1x);
    snac_if.snac_byteRec = 1'b0; snac_if.snac_timeout = 1'b0;
    rd_addr = 6'd0;
    @(negedge clk_1x);
    check("stray_done", done, 0);
    check("stray_rx_count", rx_count, 3);
    check("stray_rx0", rd_data, 8'h05);

    tx_model[0] = 8'h02; tx_model[1] = 8'h80; tx_model[2] = 8'h01;
    load_tx(3);
    run_xact(3, 33, 33, 0);
    run_xact(3, 5, 5, 0);

    tx_model[0] = 8'($urandom);
    load_tx(1);
    run_xact(1, 3, 1, 1);

    bad_len(0, 4);
    bad_len(3, 41);
    bad_len(5, 0);

    for (int i = 0; i < 3; i++) tx_model[i] = 8'($urandom);
    load_tx(3);
    snac_if.snac_ready = 1'b1;
    req_txlen = 6'd3; req_rxlen = 6'd4; req_valid = 1'b1;
    @(negedge clk_1x);
    req_valid = 1'b0;
    wait_start(got);
    check("rst_xact_start", got, 1);
    snac_if.snac_ready = 1'b0;
    repeat (3) @(negedge clk_1x);
    d0 = n_done;
    reset = 1'b0;
    rd_addr = 6'd0;
    @(negedge clk_1x);
    check("mid_req_ready", req_ready, 1);
    check("mid_done", done, 0);
    check("mid_status", status, 0);
    check("mid_rx_count", rx_count, 0);
    check("mid_start", snac_if.snac_start, 0);
    check("mid_topad", snac_if.snac_toPad_ena, 0);
    check("mid_cmd", snac_if.snac_cmdData, 0);
    check("mid_sendcnt", snac_if.snac_sendCnt, 0);
    check("mid_recvcnt", snac_if.snac_receiveCnt, 0);
    check("mid_rd_data", rd_data, 0);
    reset = 1'b1;
    snac_if.snac_ready = 1'b1;
    repeat (2) @(negedge clk_1x);
    check("mid_no_done", n_done - d0, 0);
    run_xact(3, 4, 4, 0);

    for (int it = 0; it < 10; it++) begin
      tl = $urandom_range(1, 40);
      rl = $urandom_range(1, 40);
      tm = $urandom_range(0, 2);
      if (tm == 0) nb = rl;
      else if (tm == 1) nb = $urandom_range(0, rl - 1);
      else nb = $urandom_range(1, rl);
      for (int i = 0; i < tl; i++) tx_model[i] = 8'($urandom);
      load_tx(tl);
      run_xact(tl, rl, nb, tm);
    end

`ifdef SNAC_XFER_WDOG_EN
    begin
      int cyc;
      tx_model[0] = 8'h01;
      load_tx(1);
      snac_if.snac_ready = 1'b1;
      req_txlen = 6'd1; req_rxlen = 6'd2; req_valid = 1'b1;
      @(negedge clk_1x);
      req_valid = 1'b0;
      wait_start(got);
      check("wdog_start", got, 1);
      snac_if.snac_ready = 1'b0;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 25000) begin
        @(negedge clk_1x);
        cyc++;
        got = done;
      end
      check("wdog_done", got, 1);
      check("wdog_status", status, 3);
      check("wdog_window", (cyc >= 19990 && cyc <= 20010), 1);
      snac_if.snac_ready = 1'b1;
      @(negedge clk_1x);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
